seg7_scan_drv: RTL and testbench

//  Time-multiplexed 7-segment display driver for the digital clock. Sits directly downstream of the

---
 rtl/seg7_scan_drv.sv | 124 ++++++++++++
 tb/tb_seg7_scan_drv.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_drv.sv
// seg7_scan_drv: multiplexed 7-segment driver; shadowed BCD frame, de-ghost blanking, active-low seg/sel.
//   clk, rst_n (async, active low); bcd_in[4*DIG_NUM] packed BCD (digit 0 in [3:0]);
//   bcd_vld capture strobe; dp_in decimal points (1 = lit); blink_mask per-digit blink (SEG_BLINK_EN only);
//   seg {dp,g..a} active low; sel digit enables active low; frame_done pulse on the last slot's final cycle.
//   Define SEG_BLINK_EN to add the blink_mask port and the frame-counted blink phase.
module seg7_scan_drv #(
  parameter int DIG_NUM      = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 83
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4*DIG_NUM-1:0] bcd_in,
  input  logic                 bcd_vld,
  input  logic [DIG_NUM-1:0]   dp_in,
`ifdef SEG_BLINK_EN
  input  logic [DIG_NUM-1:0]   blink_mask,
`endif
  output logic [7:0]           seg,
  output logic [DIG_NUM-1:0]   sel,
  output logic                 frame_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = DIG_NUM > 1 ? $clog2(DIG_NUM) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLK = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIG_NUM - 1);
  typedef enum logic {BLANK, DRIVE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*DIG_NUM-1:0] pend_bcd_q, pend_bcd_d, disp_bcd_q, disp_bcd_d;
  logic [DIG_NUM-1:0] pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d, sel_q, sel_d;
  logic [7:0] seg_q, seg_d;
  logic [3:0] nib;
  logic pend_q, pend_d, fd_q, fd_d, slot_end, frame_end, blank_dig;
  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'h40;
      4'd1:    dec7 = 7'h79;
      4'd2:    dec7 = 7'h24;
      4'd3:    dec7 = 7'h30;
      4'd4:    dec7 = 7'h19;
      4'd5:    dec7 = 7'h12;
      4'd6:    dec7 = 7'h02;
      4'd7:    dec7 = 7'h78;
      4'd8:    dec7 = 7'h00;
      4'd9:    dec7 = 7'h10;
      default: dec7 = 7'h3F;
    endcase
  endfunction
`ifdef SEG_BLINK_EN
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_FRAMES - 1);
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic phase_q, phase_d;
  always_comb begin
    bcnt_d  = frame_end ? (bcnt_q == BLK_MAX ? '0 : bcnt_q + BW'(1)) : bcnt_q;
    phase_d = frame_end && bcnt_q == BLK_MAX ? ~phase_q : phase_q;
  end
  // mask is sampled live; phase uses its next value so it switches exactly at the frame boundary
  assign blank_dig = phase_d & blink_mask[idx_d];
`else
  assign blank_dig = 1'b0;
`endif
  // pins are computed from next-state values so each registered pin lines up with the counters it reflects
  always_comb begin
    slot_end   = cnt_q == CNT_MAX;
    frame_end  = slot_end && idx_q == IDX_MAX;
    cnt_d      = slot_end ? '0 : cnt_q + CW'(1);
    idx_d      = frame_end ? '0 : slot_end ? idx_q + IW'(1) : idx_q;
    state_d    = slot_end ? (CNT_BLK == '0 ? DRIVE : BLANK) :
                 (state_q == BLANK && cnt_d >= CNT_BLK) ? DRIVE : state_q;
    pend_d     = frame_end ? 1'b0 : (pend_q | bcd_vld);
    pend_bcd_d = bcd_vld && !frame_end ? bcd_in : pend_bcd_q;
    pend_dp_d  = bcd_vld && !frame_end ? dp_in : pend_dp_q;
    // a strobe on the boundary cycle bypasses the pending register
    disp_bcd_d = !frame_end ? disp_bcd_q : bcd_vld ? bcd_in : pend_q ? pend_bcd_q : disp_bcd_q;
    disp_dp_d  = !frame_end ? disp_dp_q : bcd_vld ? dp_in : pend_q ? pend_dp_q : disp_dp_q;
    nib        = disp_bcd_d[{idx_d, 2'b00} +: 4];
    seg_d      = state_d == BLANK || blank_dig ? 8'hFF : {~disp_dp_d[idx_d], dec7(nib)};
    sel_d      = state_d == BLANK ? '1 : ~(DIG_NUM'(1) << idx_d);
    fd_d       = cnt_d == CNT_MAX && idx_d == IDX_MAX;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      pend_bcd_q <= '0;
      pend_dp_q  <= '0;
      disp_bcd_q <= '0;
      disp_dp_q  <= '0;
      seg_q      <= 8'hFF;
      sel_q      <= '1;
      fd_q       <= 1'b0;
`ifdef SEG_BLINK_EN
      bcnt_q     <= '0;
      phase_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_bcd_q <= pend_bcd_d;
      pend_dp_q  <= pend_dp_d;
      disp_bcd_q <= disp_bcd_d;
      disp_dp_q  <= disp_dp_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
      fd_q       <= fd_d;
`ifdef SEG_BLINK_EN
      bcnt_q     <= bcnt_d;
      phase_q    <= phase_d;
`endif
    end
  end
  assign seg        = seg_q;
  assign sel        = sel_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_drv.sv
// tb_seg7_scan_drv: scoreboard bench for seg7_scan_drv with DIG_NUM=6, SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2
`timescale 1ns/1ps
module tb_seg7_scan_drv;
  localparam int DN = 6;
  logic clk = 1'b0, rst_n = 1'b0, bcd_vld = 1'b0, frame_done;
  logic [23:0] bcd_in = '0;
  logic [5:0] dp_in = '0, sel;
  logic [7:0] seg;
`ifdef SEG_BLINK_EN
  logic [5:0] blink_mask = '0;
  localparam logic [5:0] BM = 6'b000011;
`else
  localparam logic [5:0] BM = 6'b000000;
`endif
  int n_chk = 0, n_pass = 0;
  logic [13:0] sb[$];
  logic [7:0] code [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
  always #5 clk = ~clk;
  seg7_scan_drv #(.DIG_NUM(6), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_vld(bcd_vld), .dp_in(dp_in),
`ifdef SEG_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg(seg), .sel(sel), .frame_done(frame_done));
  task automatic push_frame(input logic [23:0] b, input logic [5:0] d, input logic [5:0] bm);
    for (int s = 0; s < DN; s++) begin
      logic [7:0] c;
      c = code[b[4*s +: 4]];
      sb.push_back({~(6'd1 << s), bm[s] ? 8'hFF : {~d[s], c[6:0]}});
    end
  endtask
  task automatic chk(input string name, input logic [14:0] got, input logic [14:0] want);
    n_chk++;
    if (got !== want) $display("FAIL %s: got fd/sel/seg=%h want %h", name, got, want);
    else n_pass++;
  endtask
  task automatic wait_fd(input string name);
    int k = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (frame_done !== 1'b1) $display("FAIL %s: frame_done timeout got %b want 1", name, frame_done);
    else n_pass++;
  endtask
  // mode 1: strobe new data mid-frame (slot 2); mode 2: strobe on the frame_done cycle
  task automatic check_frame(input string name, input int mode, input logic [23:0] b,
                             input logic [5:0] d, input logic [5:0] bm);
    logic [13:0] e;
    logic [14:0] want;
    e = '0;
    for (int s = 0; s < DN; s++)
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        bcd_vld = 1'b0;
        if (c == 1) e = sb.size() > 0 ? sb.pop_front() : 14'h0;
        want = c == 0 ? {1'b0, 6'h3F, 8'hFF} : {s == DN-1 && c == 3, e};
        n_chk++;
        if ({frame_done, sel, seg} !== want)
          $display("FAIL %s slot%0d cyc%0d: got fd/sel/seg=%h want %h", name, s, c, {frame_done, sel, seg}, want);
        else n_pass++;
        if ((mode == 1 && s == 2 && c == 2) || (mode == 2 && s == DN-1 && c == 3)) begin
          bcd_in = b;
          dp_in = d;
          bcd_vld = 1'b1;
          push_frame(b, d, bm);
        end
      end
  endtask
  task automatic pulse_vld(input logic [23:0] b, input logic [5:0] d, input logic [5:0] bm);
    bcd_in = b;
    dp_in = d;
    bcd_vld = 1'b1;
    push_frame(b, d, bm);
    @(negedge clk);
    bcd_vld = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hold", {frame_done, sel, seg}, {1'b0, 6'h3F, 8'hFF});
    rst_n = 1'b1;
    #1 chk("reset_release", {frame_done, sel, seg}, {1'b0, 6'h3F, 8'hFF});
    @(negedge clk);
    chk("first_drive", {frame_done, sel, seg}, {1'b0, 6'h3E, 8'hC0});
  endtask
  task automatic test_basic();
    pulse_vld(24'h235959, 6'h00, 6'h00);
    wait_fd("basic_wait");
    check_frame("basic", 0, '0, '0, '0);
  endtask
  task automatic test_dash();
    pulse_vld(24'h00000A, 6'h01, 6'h00);
    wait_fd("dash_wait");
    check_frame("dash", 0, '0, '0, '0);
  endtask
  task automatic test_back_to_back();
    push_frame(24'h00000A, 6'h01, 6'h00);
    check_frame("no_tear", 1, 24'h123456, 6'h00, 6'h00);
    check_frame("pend_load", 2, 24'h98760F, 6'h2A, 6'h00);
    check_frame("direct_load", 0, '0, '0, '0);
  endtask
  task automatic test_blink();
`ifdef SEG_BLINK_EN
    blink_mask = BM;
`endif
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulse_vld(24'h235959, 6'h00, 6'h00);
    wait_fd("blink_wait");
    check_frame("blink_f1", 0, '0, '0, '0);
    push_frame(24'h235959, 6'h00, BM);
    check_frame("blink_f2", 0, '0, '0, '0);
    push_frame(24'h235959, 6'h00, BM);
    check_frame("blink_f3", 0, '0, '0, '0);
    push_frame(24'h235959, 6'h00, 6'h00);
    check_frame("blink_f4", 0, '0, '0, '0);
  endtask
  task automatic test_async_reset();
    repeat (14) @(negedge clk);
    chk("slot3_drive", {frame_done, sel, seg}, {1'b0, 6'h37, 8'h92});
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {frame_done, sel, seg}, {1'b0, 6'h3F, 8'hFF});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_slot0", {frame_done, sel, seg}, {1'b0, 6'h3E, 8'hC0});
    wait_fd("post_rst_wait");
    push_frame(24'h000000, 6'h00, 6'h00);
    check_frame("post_rst", 0, '0, '0, '0);
  endtask
  initial begin
    test_reset();
    test_basic();
    test_dash();
    test_back_to_back();
    test_blink();
    test_async_reset();
    n_chk++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
